ysyx_23060072_mem_arbiter: RTL and testbench

Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the rv32e pipeline. It sequences one outstanding transaction at a time through a request/response handshake and gives the LSU priority, with a fairness cap that guarantees fetch progress. A response watchdog converts a hung memory access into an error response, so the pipeline never deadlocks in simulation.

---
 rtl/ysyx_23060072_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_ysyx_23060072_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Memory port arbiter for the rv32e core: shares one request/response memory port
// between IFU and LSU, LSU-first with a fairness cap, plus a response watchdog.
module ysyx_23060072_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int SW = $clog2(MAX_LS + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t        r_state;
  state_t        w_nextState;
  owner_t        r_owner;
  logic [SW-1:0] r_lsStreak;
  logic [WW-1:0] r_watchdog;
  logic          w_grantLs;
  logic          w_grantIf;
  logic          w_respOk;
  logic          w_respTo;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // A timeout response zeroes rdata so stale bus data never reaches the pipeline.
  always_comb begin
    w_nextState   = r_state;
    w_grantLs     = 1'b0;
    w_grantIf     = 1'b0;
    w_respOk      = 1'b0;
    w_respTo      = 1'b0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    if_rdata      = '0;
    if_resp_err   = 1'b0;
    ls_resp_valid = 1'b0;
    ls_rdata      = '0;
    ls_resp_err   = 1'b0;
    case (r_state)
      IDLE: begin
        w_grantLs    = ls_req_valid && (!if_req_valid || (r_lsStreak < STREAK_MAX));
        w_grantIf    = !w_grantLs && if_req_valid;
        if_req_ready = w_grantIf;
        ls_req_ready = w_grantLs;
        if (w_grantLs || w_grantIf) w_nextState = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_nextState = WAIT;
      end
      WAIT: begin
        w_respOk = mem_resp_valid;
        w_respTo = !mem_resp_valid && (r_watchdog == WD_LAST);
        if (w_respOk || w_respTo) begin
          w_nextState = IDLE;
          if (r_owner == OWN_LS) begin
            ls_resp_valid = 1'b1;
            ls_rdata      = w_respOk ? mem_rdata : '0;
            ls_resp_err   = w_respTo;
          end else begin
            if_resp_valid = 1'b1;
            if_rdata      = w_respOk ? mem_rdata : '0;
            if_resp_err   = w_respTo;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request fields, owner and the LSU streak only move on an acceptance in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_IF;
      r_lsStreak <= '0;
      r_watchdog <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      r_watchdog <= (r_state == WAIT && w_nextState == WAIT) ? r_watchdog + 1'b1 : '0;
      if (w_grantLs) begin
        r_owner   <= OWN_LS;
        mem_addr  <= ls_addr;
        mem_wen   <= ls_wen;
        mem_wdata <= ls_wdata;
        mem_wmask <= ls_wmask;
        if (if_req_valid)
          r_lsStreak <= (r_lsStreak == STREAK_MAX) ? r_lsStreak : r_lsStreak + 1'b1;
        else
          r_lsStreak <= '0;
      end else if (w_grantIf) begin
        r_owner    <= OWN_IF;
        mem_addr   <= if_addr;
        mem_wen    <= 1'b0;
        mem_wdata  <= '0;
        mem_wmask  <= '0;
        r_lsStreak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Directed bench for ysyx_23060072_mem_arbiter (MAX_LS=4, TIMEOUT=8): fetch, store,
// contention fairness, watchdog timeout, reset mid-transaction and back-to-back fetches.
module tb_ysyx_23060072_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  ysyx_23060072_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_LS(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata), .if_resp_err(if_resp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata), .ls_resp_err(ls_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  // Inputs change just after the falling edge; outputs are sampled 1 ns later,
  // well clear of the next rising edge that consumes them.
  task automatic applyStimulus(input logic ifv, input logic [31:0] ifa,
                               input logic lsv, input logic [31:0] lsa,
                               input logic wen, input logic [31:0] wd, input logic [3:0] wm,
                               input logic mrr, input logic mrv, input logic [31:0] mrd);
    @(negedge clk);
    if_req_valid   = ifv;
    if_addr        = ifa;
    ls_req_valid   = lsv;
    ls_addr        = lsa;
    ls_wen         = wen;
    ls_wdata       = wd;
    ls_wmask       = wm;
    mem_req_ready  = mrr;
    mem_resp_valid = mrv;
    mem_rdata      = mrd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_memreq", {63'd0, mem_req_valid}, 64'd0);
    checkOutput("reset_memfields", {mem_addr, mem_wdata}, 64'd0);
    checkOutput("reset_wen_mask", {59'd0, mem_wen, mem_wmask}, 64'd0);
    checkOutput("reset_resp", {60'd0, if_resp_valid, if_resp_err, ls_resp_valid, ls_resp_err}, 64'd0);
    checkOutput("reset_rdata", {if_rdata, ls_rdata}, 64'd0);
    rst = 1'b0;

    // Single fetch with zero-wait memory.
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_ready", {62'd0, if_req_ready, ls_req_ready}, 64'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("fetch_req", {31'd0, mem_req_valid, mem_addr}, {31'd0, 1'b1, 32'h8000_0000});
    checkOutput("fetch_req_wen", {63'd0, mem_wen}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0413);
    checkOutput("fetch_resp", {30'd0, if_resp_valid, if_resp_err, if_rdata}, {30'd0, 2'b10, 32'h413});
    checkOutput("fetch_ls_quiet", {63'd0, ls_resp_valid}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fetch_pulse_end", {63'd0, if_resp_valid}, 64'd0);

    // Store with memory stalling the request for three cycles.
    applyStimulus(0, 0, 1, 32'h100, 1, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    checkOutput("store_ready", {62'd0, if_req_ready, ls_req_ready}, 64'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 32'h555, 0, 32'h1111_2222, 4'h3, 0, 0, 0);
      checkOutput("store_stall_addr_data", {mem_addr, mem_wdata}, {32'h100, 32'hDEAD_BEEF});
      checkOutput("store_stall_ctl", {58'd0, mem_req_valid, mem_wen, mem_wmask}, {58'd0, 2'b11, 4'hF});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("store_req_go", {63'd0, mem_req_valid}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("store_wait_quiet", {62'd0, ls_resp_valid, if_resp_valid}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    checkOutput("store_resp", {61'd0, ls_resp_valid, ls_resp_err, if_resp_valid}, {61'd0, 3'b100});

    // Contention: both requesters valid throughout; LSU gets four, then IFU one.
    for (int i = 0; i < 10; i++) begin
      logic        expIf;
      logic [31:0] expAddr;
      expIf   = (i % 5) == 4;
      expAddr = expIf ? 32'h1000 : 32'h2000 + 32'(i) * 4;
      applyStimulus(1, 32'h1000, 1, 32'h2000 + 32'(i) * 4, 0, 0, 0, 0, 0, 0);
      checkOutput("contend_grant", {62'd0, if_req_ready, ls_req_ready}, {62'd0, expIf, !expIf});
      applyStimulus(1, 32'h1000, 1, 32'h2000 + 32'(i) * 4, 0, 0, 0, 1, 0, 0);
      checkOutput("contend_addr", {31'd0, mem_wen, mem_addr}, {31'd0, 1'b0, expAddr});
      applyStimulus(1, 32'h1000, 1, 32'h2000 + 32'(i) * 4, 0, 0, 0, 0, 1, 32'hC0 + 32'(i));
      checkOutput("contend_owner", {62'd0, if_resp_valid, ls_resp_valid}, {62'd0, expIf, !expIf});
      checkOutput("contend_rdata", expIf ? {32'd0, if_rdata} : {32'd0, ls_rdata}, {32'd0, 32'hC0 + 32'(i)});
    end

    // Watchdog: memory never answers; error response in the 8th WAIT cycle.
    applyStimulus(1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_ready", {62'd0, if_req_ready, ls_req_ready}, 64'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int c = 1; c < 8; c++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hABCD);
      checkOutput("to_early", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hABCD);
    checkOutput("to_resp", {30'd0, if_resp_valid, if_resp_err, if_rdata}, {30'd0, 2'b11, 32'd0});
    checkOutput("to_ls_quiet", {63'd0, ls_resp_valid}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    checkOutput("to_late_resp", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);

    // Reset in the middle of an LSU load drops the transaction.
    applyStimulus(0, 0, 1, 32'h300, 0, 0, 4'h0, 0, 0, 0);
    checkOutput("rst_ls_ready", {62'd0, if_req_ready, ls_req_ready}, 64'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pre_addr", {32'd0, mem_addr}, 64'h300);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_fields", {31'd0, mem_req_valid, mem_addr}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
    checkOutput("rst_no_resp", {62'd0, ls_resp_valid, if_resp_valid}, 64'd0);
    checkOutput("rst_rdata", {ls_rdata, if_rdata}, 64'd0);

    // Five back-to-back fetches: accept every third cycle, addresses in order.
    for (int k = 0; k < 5; k++) begin
      logic [31:0] a;
      a = 32'h8000_0000 + 32'(k) * 4;
      applyStimulus(1, a, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("b2b_accept", {62'd0, if_req_ready, ls_req_ready}, 64'h2);
      applyStimulus(1, a + 4, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("b2b_req", {30'd0, mem_req_valid, if_req_ready, mem_addr}, {30'd0, 2'b10, a});
      applyStimulus(1, a + 4, 0, 0, 0, 0, 0, 0, 1, 32'h500 + 32'(k));
      checkOutput("b2b_resp", {29'd0, if_resp_valid, if_req_ready, ls_req_ready, if_rdata},
                  {29'd0, 3'b100, 32'h500 + 32'(k)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
